// File: rtl/spi_ram_ctrl.sv
// SPI frame decoder and round-robin arbiter sharing one synchronous RAM port with a host requester.
// Latency: SPI op reaches the RAM 2 cycles after its frame; reads return RD_LATENCY+1 cycles after the access. Backpressure: host holds its request until host_gnt, and a busy SPI path drops new frames and flags cmd_err.
module spi_ram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [9:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [7:0]            host_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout,
  output logic                  cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam logic       WCNT_LAST = 1'(RD_LATENCY - 1);

  state_t                state_q, state_d;
  logic                  wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_addr_ok_q, rd_addr_ok_d;
  logic                  spi_pend_q, spi_pend_d;
  logic                  spi_we_q, spi_we_d;
  logic [ADDR_WIDTH-1:0] spi_addr_q, spi_addr_d;
  logic [7:0]            spi_wdata_q, spi_wdata_d;
  logic                  last_host_q, last_host_d;
  logic                  own_spi_q, own_spi_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_din_q, ram_din_d;
  logic                  host_gnt_q, host_gnt_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [7:0]            host_rdata_q, host_rdata_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  cmd_err_q, cmd_err_d;

  logic [1:0] cmd;
  logic [7:0] payload;
  logic       spi_busy;
  logic       pick_spi;

  assign cmd     = rx_data[9:8];
  assign payload = rx_data[7:0];

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    rd_addr_ok_d  = rd_addr_ok_q;
    spi_pend_d    = spi_pend_q;
    spi_we_d      = spi_we_q;
    spi_addr_d    = spi_addr_q;
    spi_wdata_d   = spi_wdata_q;
    last_host_d   = last_host_q;
    own_spi_d     = own_spi_q;
    ram_en_d      = 1'b0;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    host_gnt_d    = 1'b0;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    cmd_err_d     = 1'b0;
    pick_spi      = 1'b0;
    spi_busy      = spi_pend_q || ((state_q != S_IDLE) && own_spi_q);

    // Frame decode runs first so a same-cycle read capture below still sets tx_valid.
    if (rx_valid) begin
      tx_valid_d = 1'b0;
      case (cmd)
        CMD_WADDR: wr_addr_d = payload[ADDR_WIDTH-1:0];
        CMD_WRITE: begin
          if (spi_busy) begin
            cmd_err_d = 1'b1;
          end else begin
            spi_pend_d  = 1'b1;
            spi_we_d    = 1'b1;
            spi_addr_d  = wr_addr_q;
            spi_wdata_d = payload;
          end
        end
        CMD_RADDR: begin
          rd_addr_d    = payload[ADDR_WIDTH-1:0];
          rd_addr_ok_d = 1'b1;
        end
        default: begin
          if (spi_busy || !rd_addr_ok_q) begin
            cmd_err_d = 1'b1;
          end else begin
            spi_pend_d = 1'b1;
            spi_we_d   = 1'b0;
            spi_addr_d = rd_addr_q;
          end
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        pick_spi = spi_pend_q && (!host_req || last_host_q);
        if (spi_pend_q || host_req) begin
          state_d   = S_ACCESS;
          ram_en_d  = 1'b1;
          own_spi_d = pick_spi;
          // Round-robin pointer only moves when both sides contend.
          if (spi_pend_q && host_req) begin
            last_host_d = !pick_spi;
          end
          if (pick_spi) begin
            ram_we_d   = spi_we_q;
            ram_addr_d = spi_addr_q;
            ram_din_d  = spi_wdata_q;
          end else begin
            ram_we_d   = host_we;
            ram_addr_d = host_addr;
            ram_din_d  = host_wdata;
            host_gnt_d = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (own_spi_q) begin
          spi_pend_d = 1'b0;
        end
        if (ram_we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WCNT_LAST) begin
          state_d = S_IDLE;
          if (own_spi_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = ram_dout;
          end else begin
            host_rvalid_d = 1'b1;
            host_rdata_d  = ram_dout;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wcnt_q        <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      rd_addr_ok_q  <= 1'b0;
      spi_pend_q    <= 1'b0;
      spi_we_q      <= 1'b0;
      spi_addr_q    <= '0;
      spi_wdata_q   <= 8'h00;
      last_host_q   <= 1'b1;
      own_spi_q     <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= 8'h00;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= 8'h00;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      rd_addr_ok_q  <= rd_addr_ok_d;
      spi_pend_q    <= spi_pend_d;
      spi_we_q      <= spi_we_d;
      spi_addr_q    <= spi_addr_d;
      spi_wdata_q   <= spi_wdata_d;
      last_host_q   <= last_host_d;
      own_spi_q     <= own_spi_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      host_gnt_q    <= host_gnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign host_gnt    = host_gnt_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: RD_LATENCY=1 and RD_LATENCY=2 instances on shared stimulus, each with its own RAM.
// Directed scenarios plus a randomized frame/host sequence checked against a transaction-level model.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       mem_clr;

  logic       tx_valid, host_gnt, host_rvalid, ram_en, ram_we, cmd_err;
  logic [7:0] tx_data, host_rdata, ram_addr, ram_din, ram_dout;
  logic       tx_valid_2, host_gnt_2, host_rvalid_2, ram_en_2, ram_we_2, cmd_err_2;
  logic [7:0] tx_data_2, host_rdata_2, ram_addr_2, ram_din_2, ram_dout_2;

  int total;
  int passed;

  spi_ram_ctrl #(.ADDR_WIDTH(8), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .cmd_err(cmd_err)
  );

  spi_ram_ctrl #(.ADDR_WIDTH(8), .RD_LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid_2), .tx_data(tx_data_2),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt_2), .host_rvalid(host_rvalid_2), .host_rdata(host_rdata_2),
    .ram_en(ram_en_2), .ram_we(ram_we_2), .ram_addr(ram_addr_2), .ram_din(ram_din_2),
    .ram_dout(ram_dout_2), .cmd_err(cmd_err_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAMs: one-cycle registered read, and a two-stage read pipeline.
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic [7:0] rd1, rd2_a, rd2_b;

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem1[i] <= 8'h00;
    else if (ram_en && ram_we) mem1[ram_addr] <= ram_din;
    if (ram_en && !ram_we) rd1 <= mem1[ram_addr];
  end

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem2[i] <= 8'h00;
    else if (ram_en_2 && ram_we_2) mem2[ram_addr_2] <= ram_din_2;
    if (ram_en_2 && !ram_we_2) rd2_a <= mem2[ram_addr_2];
    rd2_b <= rd2_a;
  end

  assign ram_dout   = rd1;
  assign ram_dout_2 = rd2_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; rx_data = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents a frame for one cycle; returns in the cycle after the frame.
  task automatic send(input logic [9:0] f);
    rx_valid = 1'b1;
    rx_data  = f;
    tick();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({ram_en, ram_we, ram_addr, ram_din, host_gnt, host_rvalid, host_rdata, tx_valid, tx_data, cmd_err} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {ram_en, ram_we, ram_addr, ram_din, host_gnt, host_rvalid, host_rdata, tx_valid, tx_data, cmd_err});
    else passed++;
    total++; if ({ram_en_2, ram_we_2, ram_addr_2, ram_din_2, host_gnt_2, host_rvalid_2, host_rdata_2, tx_valid_2, tx_data_2, cmd_err_2} !== '0)
      $display("FAIL reset_outputs_l2: got %h want 0", {ram_en_2, ram_we_2, ram_addr_2, ram_din_2, host_gnt_2, host_rvalid_2, host_rdata_2, tx_valid_2, tx_data_2, cmd_err_2});
    else passed++;
  endtask

  task automatic test_write();
    send(10'h0A5);
    send(10'h13C);
    total++; if (ram_en !== 1'b0) $display("FAIL wr_early: ram_en got %0b want 0", ram_en); else passed++;
    tick();
    total++; if ({ram_en, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 8'hA5, 8'h3C})
      $display("FAIL wr_access: en/we/addr/din got %0b/%0b/%h/%h want 1/1/a5/3c", ram_en, ram_we, ram_addr, ram_din);
    else passed++;
    tick();
    total++; if (ram_en !== 1'b0) $display("FAIL wr_one_cycle: ram_en got %0b want 0", ram_en); else passed++;
  endtask

  task automatic test_read();
    send(10'h2A5);
    send(10'h300);
    total++; if (cmd_err !== 1'b0) $display("FAIL rd_noerr: cmd_err got %0b want 0", cmd_err); else passed++;
    tick();
    total++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'hA5})
      $display("FAIL rd_access: en/we/addr got %0b/%0b/%h want 1/0/a5", ram_en, ram_we, ram_addr);
    else passed++;
    tick();
    total++; if (tx_valid !== 1'b0) $display("FAIL rd_tx_early: tx_valid got %0b want 0", tx_valid); else passed++;
    tick();
    total++; if ({tx_valid, tx_data} !== {1'b1, 8'h3C})
      $display("FAIL rd_tx: valid/data got %0b/%h want 1/3c", tx_valid, tx_data);
    else passed++;
    tick(); tick(); tick();
    total++; if ({tx_valid, tx_data} !== {1'b1, 8'h3C})
      $display("FAIL rd_tx_hold: valid/data got %0b/%h want 1/3c", tx_valid, tx_data);
    else passed++;
    send(10'h000);
    total++; if (tx_valid !== 1'b0) $display("FAIL rd_tx_clear: tx_valid got %0b want 0", tx_valid); else passed++;
  endtask

  task automatic test_read_no_addr();
    logic saw_en, saw_tx;
    do_reset();
    send(10'h300);
    total++; if (cmd_err !== 1'b1) $display("FAIL noaddr_err: cmd_err got %0b want 1", cmd_err); else passed++;
    tick();
    total++; if (cmd_err !== 1'b0) $display("FAIL noaddr_err_pulse: cmd_err got %0b want 0", cmd_err); else passed++;
    saw_en = 1'b0; saw_tx = 1'b0;
    for (int k = 0; k < 5; k++) begin
      saw_en |= ram_en; saw_tx |= tx_valid;
      tick();
    end
    total++; if ({saw_en, saw_tx} !== 2'b00) $display("FAIL noaddr_quiet: ram_en/tx_valid seen %0b/%0b want 0/0", saw_en, saw_tx); else passed++;
  endtask

  task automatic test_arbitration();
    do_reset();
    send(10'h020);
    send(10'h111);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
    tick();
    total++; if ({ram_en, host_gnt, ram_addr, ram_din} !== {1'b1, 1'b0, 8'h20, 8'h11})
      $display("FAIL tie1_spi: en/gnt/addr/din got %0b/%0b/%h/%h want 1/0/20/11", ram_en, host_gnt, ram_addr, ram_din);
    else passed++;
    tick();
    total++; if (ram_en !== 1'b0) $display("FAIL tie1_gap: ram_en got %0b want 0", ram_en); else passed++;
    tick();
    total++; if ({ram_en, host_gnt, ram_addr, ram_din} !== {1'b1, 1'b1, 8'h30, 8'h77})
      $display("FAIL tie1_host: en/gnt/addr/din got %0b/%0b/%h/%h want 1/1/30/77", ram_en, host_gnt, ram_addr, ram_din);
    else passed++;
    host_req = 1'b0;
    tick();
    send(10'h122);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h31; host_wdata = 8'h88;
    tick();
    total++; if ({ram_en, host_gnt, ram_addr, ram_din} !== {1'b1, 1'b1, 8'h31, 8'h88})
      $display("FAIL tie2_host: en/gnt/addr/din got %0b/%0b/%h/%h want 1/1/31/88", ram_en, host_gnt, ram_addr, ram_din);
    else passed++;
    host_req = 1'b0;
    tick();
    tick();
    total++; if ({ram_en, host_gnt, ram_addr, ram_din} !== {1'b1, 1'b0, 8'h20, 8'h22})
      $display("FAIL tie2_spi: en/gnt/addr/din got %0b/%0b/%h/%h want 1/0/20/22", ram_en, host_gnt, ram_addr, ram_din);
    else passed++;
    tick();
  endtask

  task automatic test_rd_latency2();
    do_reset();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
    tick();
    total++; if (host_gnt_2 !== 1'b1) $display("FAIL l2_wr_gnt: host_gnt got %0b want 1", host_gnt_2); else passed++;
    host_req = 1'b0;
    tick();
    host_req = 1'b1; host_we = 1'b0;
    tick();
    total++; if ({host_gnt_2, ram_en_2, ram_we_2} !== 3'b110) $display("FAIL l2_rd_gnt: gnt/en/we got %b want 110", {host_gnt_2, ram_en_2, ram_we_2}); else passed++;
    host_req = 1'b0;
    tick();
    total++; if (host_rvalid_2 !== 1'b0) $display("FAIL l2_rvalid_a1: got %0b want 0", host_rvalid_2); else passed++;
    tick();
    total++; if (host_rvalid_2 !== 1'b0) $display("FAIL l2_rvalid_a2: got %0b want 0", host_rvalid_2); else passed++;
    total++; if ({host_rvalid, host_rdata} !== {1'b1, 8'h5A}) $display("FAIL l1_rvalid_a2: valid/data got %0b/%h want 1/5a", host_rvalid, host_rdata); else passed++;
    tick();
    total++; if ({host_rvalid_2, host_rdata_2} !== {1'b1, 8'h5A}) $display("FAIL l2_rvalid_a3: valid/data got %0b/%h want 1/5a", host_rvalid_2, host_rdata_2); else passed++;
    tick();
    total++; if (host_rvalid_2 !== 1'b0) $display("FAIL l2_rvalid_a4: got %0b want 0", host_rvalid_2); else passed++;
  endtask

  task automatic test_reset_mid_read();
    logic saw_tx;
    do_reset();
    send(10'h240);
    send(10'h300);
    tick();
    total++; if (ram_en !== 1'b1) $display("FAIL mid_access: ram_en got %0b want 1", ram_en); else passed++;
    tick();
    rst = 1'b1;
    #1;
    total++; if ({ram_en, ram_addr, tx_valid, host_rvalid, cmd_err} !== '0)
      $display("FAIL mid_rst_outputs: en/addr/tx/rv/err got %0b/%h/%0b/%0b/%0b want all 0", ram_en, ram_addr, tx_valid, host_rvalid, cmd_err);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    send(10'h300);
    total++; if (cmd_err !== 1'b1) $display("FAIL mid_rst_err: cmd_err got %0b want 1", cmd_err); else passed++;
    saw_tx = 1'b0;
    for (int k = 0; k < 5; k++) begin
      saw_tx |= tx_valid;
      tick();
    end
    total++; if (saw_tx !== 1'b0) $display("FAIL mid_rst_tx: tx_valid seen %0b want 0", saw_tx); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(10'h050);
    send(10'h1AA);
    total++; if (cmd_err !== 1'b0) $display("FAIL b2b_first: cmd_err got %0b want 0", cmd_err); else passed++;
    send(10'h1BB);
    total++; if ({cmd_err, ram_en, ram_din} !== {1'b1, 1'b1, 8'hAA})
      $display("FAIL b2b_drop_wr: err/en/din got %0b/%0b/%h want 1/1/aa", cmd_err, ram_en, ram_din);
    else passed++;
    tick();
    send(10'h250);
    send(10'h300);
    send(10'h300);
    total++; if ({cmd_err, ram_en, ram_we} !== 3'b110) $display("FAIL b2b_drop_pend: err/en/we got %b want 110", {cmd_err, ram_en, ram_we}); else passed++;
    send(10'h300);
    total++; if (cmd_err !== 1'b1) $display("FAIL b2b_drop_flight: cmd_err got %0b want 1", cmd_err); else passed++;
    tick();
    total++; if ({tx_valid, tx_data} !== {1'b1, 8'hAA}) $display("FAIL b2b_tx: valid/data got %0b/%h want 1/aa", tx_valid, tx_data); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] m_mem [256];
    logic [7:0] m_wr, m_rd, m_tx_dat, pl, a, d, got_d;
    logic       m_ok, m_tx_vld, exp_err, we, got;
    int         cmd_i;
    do_reset();
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_wr = 8'h00; m_rd = 8'h00; m_ok = 1'b0; m_tx_vld = 1'b0; m_tx_dat = 8'h00;
    for (int it = 0; it < 50; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        cmd_i = $urandom_range(0, 3);
        if (cmd_i == 0 || cmd_i == 2) pl = 8'hA0 | 8'($urandom_range(0, 7));
        else pl = 8'($urandom_range(0, 255));
        exp_err = (cmd_i == 3) && !m_ok;
        send({2'(cmd_i), pl});
        total++; if (cmd_err !== exp_err) $display("FAIL rnd_err[%0d]: cmd %0d cmd_err got %0b want %0b", it, cmd_i, cmd_err, exp_err); else passed++;
        m_tx_vld = 1'b0;
        case (cmd_i)
          0: m_wr = pl;
          1: m_mem[m_wr] = pl;
          2: begin m_rd = pl; m_ok = 1'b1; end
          default: if (m_ok) begin m_tx_vld = 1'b1; m_tx_dat = m_mem[m_rd]; end
        endcase
        for (int k = 0; k < 6; k++) tick();
      end else begin
        we = 1'($urandom_range(0, 1));
        a  = 8'hA0 | 8'($urandom_range(0, 7));
        d  = 8'($urandom_range(0, 255));
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
          tick();
          if (host_gnt) got = 1'b1;
        end
        host_req = 1'b0;
        total++; if (got !== 1'b1) $display("FAIL rnd_gnt[%0d]: host_gnt seen %0b want 1", it, got); else passed++;
        if (we) begin
          m_mem[a] = d;
          tick(); tick();
        end else begin
          got = 1'b0; got_d = 8'h00;
          for (int k = 0; k < 5 && !got; k++) begin
            tick();
            if (host_rvalid) begin got = 1'b1; got_d = host_rdata; end
          end
          total++; if ({got, got_d} !== {1'b1, m_mem[a]})
            $display("FAIL rnd_hrd[%0d]: addr %h valid/data got %0b/%h want 1/%h", it, a, got, got_d, m_mem[a]);
          else passed++;
          tick();
        end
      end
      total++; if (tx_valid !== m_tx_vld || (m_tx_vld && tx_data !== m_tx_dat))
        $display("FAIL rnd_tx[%0d]: valid/data got %0b/%h want %0b/%h", it, tx_valid, tx_data, m_tx_vld, m_tx_dat);
      else passed++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, total);
    $fatal(1);
  end

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; mem_clr = 1'b0;
    rx_valid = 1'b0; rx_data = '0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_read_no_addr();
    test_arbitration();
    test_rd_latency2();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
